inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Front-end fetch stage feeding the decoder. Fetches one 32-bit instruction per request from the
//  icache, predicts next PC (JAL taken, all else PC+4), buffers {pc,inst} pairs in a FIFO.
//  Presents FIFO head to the decoder under a valid/ready handshake. Flushes and redirects on clear.
// PARAMETERS
//  QUEUE_DEPTH   8   FIFO entries; power of two, >=2
//  RESET_PC      0   first fetch address after reset
// PORTS
//  clk_in           in   1   clock, all state on rising edge
//  rst_in           in   1   asynchronous reset, active-high
//  rdy_in           in   1   global enable; low = hold all state, no side effects
//  clear            in   1   pipeline flush (mispredict), one-cycle pulse
//  clear_pc         in   32  redirect target, valid with clear
//  to_icache_valid  out  1   fetch request pending
//  to_icache_addr   out  32  fetch address, stable while to_icache_valid
//  from_icache_valid in  1   response strobe for the pending request
//  from_icache_inst in   32  fetched instruction
//  from_dec_ready   in   1   decoder accepts head this cycle
//  to_dec_valid     out  1   FIFO non-empty
//  to_dec_pc        out  32  PC of head entry
//  to_dec_inst      out  32  instruction of head entry
// BEHAVIOUR
//  Reset: state=IDLE, fetch_pc=RESET_PC, FIFO empty (head=tail=count=0), to_icache_valid=0,
//   to_icache_addr=RESET_PC, to_dec_valid=0. Reset mid-request abandons it; later icache strobe ignored (state IDLE).
//  rdy_in=0: no state, pointer or output-register change; clear ignored that cycle.
//  FSM (registered): IDLE, WAIT, DISCARD.
//   IDLE: if count < QUEUE_DEPTH -> to_icache_valid<=1, to_icache_addr<=fetch_pc, ->WAIT. Else stay.
//   WAIT: hold request. On from_icache_valid: push {fetch_pc, inst}; to_icache_valid<=0;
//     fetch_pc<=next_pc; ->IDLE. At most one outstanding request.
//   DISCARD: to_icache_valid=0; wait for from_icache_valid of abandoned request, drop it, ->IDLE.
//  next_pc: opcode 7'b1101111 (JAL) -> fetch_pc + sext({i[31],i[19:12],i[20],i[30:21],1'b0});
//   otherwise fetch_pc+4. 32-bit wrap-around, no overflow detection. Branches/JALR predicted not-taken.
//  Issue gate counts the in-flight request: IDLE issues only if count<DEPTH, and a push in WAIT
//   is therefore always accepted (no overflow possible; full FIFO stalls fetch only).
//  Output: to_dec_valid = (count!=0); pc/inst driven combinationally from head entry.
//   Pop when to_dec_valid & from_dec_ready: head++ (mod DEPTH), count--.
//   Push and pop same cycle: both pointers advance, count unchanged. Empty: ready ignored.
//  clear (rdy_in=1) has priority over every other event that cycle:
//   FIFO flushed (head=tail=count=0), no pop, no push, fetch_pc<=clear_pc.
//   From WAIT without from_icache_valid -> DISCARD, to_icache_valid<=0.
//   From WAIT with from_icache_valid same cycle -> response dropped, ->IDLE.
//   From IDLE/DISCARD -> IDLE (DISCARD with no strobe stays DISCARD).
//   First post-clear request issues the cycle after clear, address clear_pc.
//  Latency: request->response is icache-defined; response->to_dec_valid = 1 cycle (registered push).
// TESTING
//  Reset, RESET_PC=0, icache 1-cycle: addr 0,4,8 requested; decoder sees pc 0,4,8 in order.
//  JAL at 0x10 encoding imm=+0x20 -> next request addr 0x30; imm=-8 -> 0x08.
//  Hold from_dec_ready=0, DEPTH=8: exactly 8 pushes, to_icache_valid stays 0; raise ready -> fetch resumes.
//  clear with clear_pc=0x100 while WAIT, strobe 2 cycles later: strobe data never reaches decoder;
//   next request addr 0x100, to_dec_valid=0 until that response.
//  clear same cycle as from_icache_valid and from_dec_ready=1: FIFO empties, response dropped, no pop counted.
//  Steady push+pop with ready=1: count stays constant; rdy_in=0 for 3 cycles freezes addr/outputs/pointers.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue_if
//   Bundles the two handshakes of the fetch stage:
//   - icache request/response:
//       to_icache_valid, to_icache_addr     (fetch stage -> icache)
//       from_icache_valid, from_icache_inst (icache -> fetch stage)
//   - decoder valid/ready:
//       to_dec_valid, to_dec_pc, to_dec_inst (fetch stage -> decoder)
//       from_dec_ready                       (decoder -> fetch stage)
//   master : the fetch queue side.
//   slave  : the environment side (the icache plus the decoder).
// ----------------------------------------------------------------------------
interface inst_fetch_queue_if;
  logic        to_icache_valid;
  logic [31:0] to_icache_addr;
  logic        from_icache_valid;
  logic [31:0] from_icache_inst;
  logic        from_dec_ready;
  logic        to_dec_valid;
  logic [31:0] to_dec_pc;
  logic [31:0] to_dec_inst;

  modport master (
    output to_icache_valid, to_icache_addr,
    input  from_icache_valid, from_icache_inst,
    input  from_dec_ready,
    output to_dec_valid, to_dec_pc, to_dec_inst
  );

  modport slave (
    input  to_icache_valid, to_icache_addr,
    output from_icache_valid, from_icache_inst,
    output from_dec_ready,
    input  to_dec_valid, to_dec_pc, to_dec_inst
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue
//   Front-end fetch stage. It issues one icache request at a time and
//   predicts the next PC: JAL is taken, everything else falls through to
//   PC+4. Each returned {pc, inst} pair is buffered in a FIFO, and the FIFO
//   head is offered to the decoder through a valid/ready handshake. A clear
//   pulse flushes the FIFO and redirects fetch. If a request is still in
//   flight at that moment, its late response is discarded.
//
// Ports
//   clk_in    in   clock; all state changes on the rising edge
//   rst_in    in   asynchronous reset, active high
//   rdy_in    in   global enable; when low, all state is held
//   clear     in   flush/redirect pulse
//   clear_pc  in   redirect target, sampled together with clear
//   bus       if   icache and decoder handshakes (master side)
// ----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int          QUEUE_DEPTH = 8,      // power of two, >= 2
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear,
  input  logic [31:0]         clear_pc,
  inst_fetch_queue_if.master  bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               req_valid_q, req_valid_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0] pc_mem   [QUEUE_DEPTH];
  logic [31:0] inst_mem [QUEUE_DEPTH];

  // --------------------------------------------------------------------------
  // Event decode. Clear overrides push, pop and issue. A low rdy_in
  // suppresses every event.
  // --------------------------------------------------------------------------
  logic        live;
  logic        fifo_has_room;
  logic        issue_en;
  logic        push_en;
  logic        pop_en;

  assign live          = rdy_in & ~clear;
  // Only one request can be in flight, and requests issue only from IDLE,
  // so checking for room at issue time is enough to guarantee the push.
  assign fifo_has_room = (count_q < CNT_W'(QUEUE_DEPTH));
  assign issue_en      = live & (state_q == ST_IDLE) & fifo_has_room;
  assign push_en       = live & (state_q == ST_WAIT) & bus.from_icache_valid;
  assign pop_en        = live & (count_q != '0) & bus.from_dec_ready;

  // --------------------------------------------------------------------------
  // Next-PC prediction: a JAL is followed using its J-type immediate.
  // Conditional branches and JALR are predicted not taken.
  // --------------------------------------------------------------------------
  logic [31:0] resp_inst;
  logic        is_jal;
  logic [31:0] jal_imm;
  logic [31:0] next_pc;

  assign resp_inst = bus.from_icache_inst;
  assign is_jal    = (resp_inst[6:0] == 7'b1101111);
  assign jal_imm   = {{11{resp_inst[31]}}, resp_inst[31], resp_inst[19:12],
                      resp_inst[20], resp_inst[30:21], 1'b0};
  assign next_pc   = fetch_pc_q + (is_jal ? jal_imm : 32'd4);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!clear && fifo_has_room) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A clear without a response leaves the request in flight.
          // Its response must still be absorbed before new fetches start.
          if (bus.from_icache_valid) begin
            state_d = ST_IDLE;
          end else if (clear) begin
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (bus.from_icache_valid) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM outputs and datapath next state
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;

    if (rdy_in && clear) begin
      fetch_pc_d  = clear_pc;
      req_valid_d = 1'b0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
    end else begin
      if (issue_en) begin
        req_valid_d = 1'b1;
        req_addr_d  = fetch_pc_q;
      end
      if (push_en) begin
        req_valid_d = 1'b0;
        fetch_pc_d  = next_pc;
        tail_d      = tail_q + PTR_W'(1);
      end
      if (pop_en) begin
        head_d = head_q + PTR_W'(1);
      end
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage. The head entry is read asynchronously so the decoder sees
  // a new entry in the cycle right after the push.
  always_ff @(posedge clk_in) begin
    if (push_en) begin
      pc_mem[tail_q]   <= fetch_pc_q;
      inst_mem[tail_q] <= resp_inst;
    end
  end

  assign bus.to_icache_valid = req_valid_q;
  assign bus.to_icache_addr  = req_addr_q;
  assign bus.to_dec_valid    = (count_q != '0);
  assign bus.to_dec_pc       = pc_mem[head_q];
  assign bus.to_dec_inst     = inst_mem[head_q];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Directed bench for inst_fetch_queue (DEPTH=8, RESET_PC=0).
//   The icache responder returns one instruction per request after a
//   configurable delay. It holds its strobe until the DUT samples it with
//   rdy_in high. The model tracks a queue of {pc,inst} entries, the fetch
//   PC, the visible request, and whether the in-flight response is doomed.
// ----------------------------------------------------------------------------
module tb_inst_fetch_queue;
  localparam int DEPTH = 8;

  logic        clk_in   = 1'b0;
  logic        rst_in   = 1'b1;
  logic        rdy_in   = 1'b1;
  logic        clear    = 1'b0;
  logic [31:0] clear_pc = 32'h0;

  inst_fetch_queue_if ifq ();

  inst_fetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear    (clear),
    .clear_pc (clear_pc),
    .bus      (ifq)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_at(input string nm, input logic [31:0] q[$], input int idx,
                        input logic [31:0] exp);
    logic [31:0] v;
    v = (idx < q.size()) ? q[idx] : 32'hxxxxxxxx;
    chk(nm, v, exp);
  endtask

  // ---------------- instruction memory seen by the icache ----------------
  logic [31:0] imem [logic [31:0]];

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return {a[11:0], 20'h00013};     // addi x0,x0,imm: never a JAL
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pop_log[$];
  logic [31:0] m_fpc  = 32'h0;
  logic [31:0] m_addr = 32'h0;
  bit          m_busy   = 1'b0;   // a response is still owed by the icache
  bit          m_doomed = 1'b0;   // that response must be dropped
  bit          resp_taken = 1'b0;

  function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] i);
    logic signed [20:0] imm21;
    if (i[6:0] != 7'b1101111) return pc + 32'd4;
    imm21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    return pc + 32'(int'(imm21));
  endfunction

  initial begin
    forever begin
      @(posedge clk_in);
      if (rst_in) begin
        m_q.delete();
        m_fpc = 32'h0; m_addr = 32'h0;
        m_busy = 1'b0; m_doomed = 1'b0; resp_taken = 1'b0;
      end else begin
        int  old_n;
        bit  fv;
        bit  popping;
        ent_t e;
        fv = ifq.from_icache_valid;
        resp_taken = fv && rdy_in;
        if (rdy_in) begin
          if (clear) begin
            m_q.delete();
            m_fpc = clear_pc;
            if (m_busy) begin
              if (fv) begin m_busy = 1'b0; m_doomed = 1'b0; end
              else    m_doomed = 1'b1;
            end
          end else begin
            old_n   = m_q.size();
            popping = (old_n > 0) && ifq.from_dec_ready;
            if (m_busy) begin
              if (fv) begin
                if (!m_doomed) begin
                  e.pc = m_fpc; e.inst = ifq.from_icache_inst;
                  m_q.push_back(e);
                  m_fpc = predict(m_fpc, ifq.from_icache_inst);
                end
                m_busy = 1'b0; m_doomed = 1'b0;
              end
            end else if (old_n < DEPTH) begin
              m_busy = 1'b1;
              m_addr = m_fpc;
            end
            if (popping) begin
              m_pop_log.push_back(m_q[0].pc);
              void'(m_q.pop_front());
            end
          end
        end
      end
    end
  end

  // ---------------- icache responder ----------------
  int          lat = 0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] req_log[$];

  initial begin
    ifq.from_icache_valid = 1'b0;
    ifq.from_icache_inst  = 32'h0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        ifq.from_icache_valid = 1'b0;
        pend = 1'b0;
      end else if (!(ifq.from_icache_valid && !resp_taken)) begin
        ifq.from_icache_valid = 1'b0;
        if (!pend && ifq.to_icache_valid) begin
          pend  = 1'b1;
          cnt   = lat;
          paddr = ifq.to_icache_addr;
          req_log.push_back(ifq.to_icache_addr);
        end
        if (pend) begin
          if (cnt == 0) begin
            ifq.from_icache_valid = 1'b1;
            ifq.from_icache_inst  = inst_at(paddr);
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        chk("icache_valid", {31'd0, ifq.to_icache_valid}, {31'd0, m_busy && !m_doomed});
        chk("icache_addr", ifq.to_icache_addr, m_addr);
        chk("dec_valid", {31'd0, ifq.to_dec_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
          chk("dec_pc", ifq.to_dec_pc, m_q[0].pc);
          chk("dec_inst", ifq.to_dec_inst, m_q[0].inst);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_clear(input logic [31:0] pc);
    clear    = 1'b1;
    clear_pc = pc;
    step();
    clear    = 1'b0;
  endtask

  initial begin
    int base;
    int pb;
    bit hit;
    logic [31:0] snap_addr, snap_pc;
    bit snap_valid;

    ifq.from_dec_ready = 1'b1;
    imem[32'h10] = 32'h0200006F;          // jal x0,+0x20
    repeat (3) @(negedge clk_in);
    chk("rst_icache_valid", {31'd0, ifq.to_icache_valid}, 32'd0);
    chk("rst_icache_addr", ifq.to_icache_addr, 32'h0);
    chk("rst_dec_valid", {31'd0, ifq.to_dec_valid}, 32'd0);
    #1 rst_in = 1'b0;

    // Sequential fetch from reset, then a taken JAL at 0x10.
    run(24);
    chk_at("req0", req_log, 0, 32'h0);
    chk_at("req1", req_log, 1, 32'h4);
    chk_at("req2", req_log, 2, 32'h8);
    chk_at("pop0", m_pop_log, 0, 32'h0);
    chk_at("pop1", m_pop_log, 1, 32'h4);
    chk_at("pop2", m_pop_log, 2, 32'h8);
    chk_at("jal_src", req_log, 4, 32'h10);
    chk_at("jal_fwd", req_log, 5, 32'h30);

    // Backward JAL at 0x10 (imm=-8).
    imem[32'h10] = 32'hFF9FF06F;
    pulse_clear(32'h10);
    base = req_log.size(); pb = m_pop_log.size();
    run(12);
    chk_at("jalb_src", req_log, base, 32'h10);
    chk_at("jalb_tgt", req_log, base + 1, 32'h08);
    chk_at("jalb_nxt", req_log, base + 2, 32'h0C);
    chk_at("jalb_pop", m_pop_log, pb + 1, 32'h08);

    // Decoder stalled: exactly DEPTH pushes, then fetch stops.
    ifq.from_dec_ready = 1'b0;
    pulse_clear(32'h200);
    base = req_log.size();
    run(40);
    chk("full_reqs", 32'(req_log.size() - base), 32'd8);
    chk("full_count", 32'(m_q.size()), 32'd8);
    chk("full_no_req", {31'd0, ifq.to_icache_valid}, 32'd0);
    ifq.from_dec_ready = 1'b1;
    run(6);
    chk("resume", {31'd0, (req_log.size() - base) > 8}, 32'd1);

    // Clear while a request is outstanding; its response arrives later.
    lat = 2;
    run(10);
    base = req_log.size(); hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      step();
      hit = (req_log.size() > base);
    end
    chk("wait_req", {31'd0, hit}, 32'd1);
    pulse_clear(32'h100);
    chk("discard_dec_valid", {31'd0, ifq.to_dec_valid}, 32'd0);
    chk("discard_no_req", {31'd0, ifq.to_icache_valid}, 32'd0);
    base = req_log.size(); pb = m_pop_log.size();
    run(14);
    chk_at("redir_req", req_log, base, 32'h100);
    chk_at("redir_pop", m_pop_log, pb, 32'h100);

    // Clear coinciding with a response and a ready decoder.
    lat = 1;
    ifq.from_dec_ready = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      step();
      hit = ifq.from_icache_valid && ifq.to_dec_valid;
    end
    chk("wait_collide", {31'd0, hit}, 32'd1);
    ifq.from_dec_ready = 1'b1;
    pb = m_pop_log.size();
    pulse_clear(32'h500);
    chk("collide_empty", {31'd0, ifq.to_dec_valid}, 32'd0);
    chk("collide_no_pop", 32'(m_pop_log.size() - pb), 32'd0);
    base = req_log.size();
    run(6);
    chk_at("collide_req", req_log, base, 32'h500);

    // Steady state: every push paired with a pop keeps the count at 3.
    lat = 0;
    ifq.from_dec_ready = 1'b0;
    pulse_clear(32'h400);
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      step();
      hit = (m_q.size() == 3);
    end
    chk("wait_fill3", {31'd0, hit}, 32'd1);
    for (int k = 0; k < 12; k++) begin
      ifq.from_dec_ready = ifq.from_icache_valid;
      step();
    end
    chk("steady_count", 32'(m_q.size()), 32'd3);
    chk("steady_dec_valid", {31'd0, ifq.to_dec_valid}, 32'd1);

    // rdy_in low for three cycles freezes everything.
    snap_addr  = m_addr;
    snap_valid = m_busy && !m_doomed;
    snap_pc    = m_q[0].pc;
    ifq.from_dec_ready = 1'b1;
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("frz_addr", ifq.to_icache_addr, snap_addr);
      chk("frz_valid", {31'd0, ifq.to_icache_valid}, {31'd0, snap_valid});
      chk("frz_pc", ifq.to_dec_pc, snap_pc);
    end
    rdy_in = 1'b1;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
